// File: rtl/stupidrv_pkg.sv
// Shared types and constants for the stupidrv memory arbiter.
package stupidrv_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } memarb_state_e;

  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;
  localparam logic [3:0]  WSTRB_READ = 4'b0000;

endpackage

// File: rtl/stupidrv_memarb_perf.sv
// Performance counters for the memory arbiter: granted data accesses and stall cycles.
module stupidrv_memarb_perf #(
  parameter int PERF_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  data_grant,
  input  logic                  stall,
  output logic [PERF_WIDTH-1:0] perf_data_cnt,
  output logic [PERF_WIDTH-1:0] perf_stall_cnt
);

  localparam logic [PERF_WIDTH-1:0] ONE = 1;

  logic [PERF_WIDTH-1:0] data_cnt_reg;
  logic [PERF_WIDTH-1:0] stall_cnt_reg;

  // Counters wrap naturally at 2^PERF_WIDTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_cnt_reg  <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (data_grant) data_cnt_reg <= data_cnt_reg + ONE;
      if (stall)      stall_cnt_reg <= stall_cnt_reg + ONE;
    end
  end

  assign perf_data_cnt  = data_cnt_reg;
  assign perf_stall_cnt = stall_cnt_reg;

endmodule

// File: rtl/stupidrv_memarb.sv
// Fetch/data arbiter in front of the unified single-port RAM of stupidrv.
// Optional counters are built when STUPIDRV_MEMARB_PERF_EN is defined.
module stupidrv_memarb
  import stupidrv_pkg::*;
#(
  parameter int ADDR_BITS = 14
`ifdef STUPIDRV_MEMARB_PERF_EN
  , parameter int PERF_WIDTH = 32
`endif
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ext_stall,
  output logic                 stall,
  input  logic [31:0]          imem_addr,
  output logic [31:0]          imem_data,
  input  logic                 dmem_valid,
  input  logic [31:0]          dmem_addr,
  input  logic [3:0]           dmem_wstrb,
  input  logic [31:0]          dmem_wdata,
  output logic [31:0]          dmem_rdata,
  output logic                 mem_en,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [3:0]           mem_wstrb,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata
`ifdef STUPIDRV_MEMARB_PERF_EN
  , output logic [PERF_WIDTH-1:0] perf_data_cnt
  , output logic [PERF_WIDTH-1:0] perf_stall_cnt
`endif
);

  memarb_state_e state_reg, state_next;
  logic          rst_q;
  logic          last_fetch_q;
  logic          last_read_q;
  logic [31:0]   insn_hold;
  logic [31:0]   data_q;
  logic          data_grant;

  // Byte-offset and out-of-range address bits are deliberately dropped (addresses wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{imem_addr[31:ADDR_BITS+2], imem_addr[1:0],
                              dmem_addr[31:ADDR_BITS+2], dmem_addr[1:0]};

  always_comb begin
    state_next = state_reg;
    data_grant = 1'b0;
    mem_en     = 1'b1;
    mem_addr   = imem_addr[ADDR_BITS+1:2];
    mem_wstrb  = WSTRB_READ;
    mem_wdata  = '0;
    stall      = ext_stall;
    if (reset) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          // The core's store decode is not reset-gated, so hold off for one cycle after reset.
          if (dmem_valid && !rst_q) begin
            data_grant = 1'b1;
            mem_addr   = dmem_addr[ADDR_BITS+1:2];
            mem_wstrb  = dmem_wstrb;
            mem_wdata  = dmem_wdata;
            stall      = 1'b1;
            state_next = DATA;
          end
        end
        DATA: begin
          if (!ext_stall) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      rst_q        <= 1'b1;
      last_fetch_q <= 1'b0;
      last_read_q  <= 1'b0;
      insn_hold    <= NOP_INSN;
      data_q       <= '0;
    end else begin
      state_reg    <= state_next;
      rst_q        <= 1'b0;
      last_fetch_q <= !data_grant;
      last_read_q  <= data_grant && (dmem_wstrb == WSTRB_READ);
      if (last_fetch_q) insn_hold <= mem_rdata;
      // First DATA cycle is the only one not preceded by a fetch.
      if (state_reg == DATA && !last_fetch_q) data_q <= mem_rdata;
    end
  end

  assign imem_data  = last_fetch_q ? mem_rdata : insn_hold;
  assign dmem_rdata = last_read_q  ? mem_rdata : data_q;

`ifdef STUPIDRV_MEMARB_PERF_EN
  stupidrv_memarb_perf #(
    .PERF_WIDTH(PERF_WIDTH)
  ) u_perf (
    .clock          (clock),
    .reset          (reset),
    .data_grant     (data_grant),
    .stall          (stall && !reset),
    .perf_data_cnt  (perf_data_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );
`endif

endmodule
